// File: rtl/mouse_axis_emu_if.sv
// rtl/mouse_axis_emu_if.sv - mouse/joystick input and axis output bundle for mouse_axis_emu
interface mouse_axis_emu_if #(
   parameter int WIDTH = 8
);
   logic [24:0]             ps2_mouse;
   logic [15:0]             joya;
   logic [7:0]              joy;
   logic                    cpu_halt;
   logic                    spring;
   logic signed [WIDTH-1:0] ax;
   logic signed [WIDTH-1:0] ay;
   logic [7:0]              j;
   logic                    emu_active;

   modport master (
      output ps2_mouse, joya, joy, cpu_halt, spring,
      input  ax, ay, j, emu_active
   );

   modport slave (
      input  ps2_mouse, joya, joy, cpu_halt, spring,
      output ax, ay, j, emu_active
   );
endinterface

// File: rtl/mouse_axis_emu.sv
// rtl/mouse_axis_emu.sv - PS/2 mouse to analog axis emulator; spring-return built with MOUSE_AXIS_DECAY_EN
module mouse_axis_emu #(
   parameter int WIDTH     = 8,
   parameter int SHIFT     = 1,
   parameter int STEP_MAX  = 10,
   parameter int INVERT_Y  = 0,
   parameter int DECAY_DIV = 16384
) (
   input logic              clk_sys,
   input logic              RESET_N,
   mouse_axis_emu_if.slave  bus
);
   localparam int AMAX = (1 << (WIDTH - 1)) - 1;
   localparam int AMIN = -(1 << (WIDTH - 1));
   localparam logic signed [WIDTH:0] ONE = (WIDTH + 1)'(1);

   logic                    emu_q, emu_d;
   logic signed [WIDTH:0]   mx_q, mx_d, my_q, my_d;
   logic                    old_stb_q, old_stb_d;
   logic                    primed_q, primed_d;
   logic signed [WIDTH-1:0] ax_q, ay_q;
   logic [7:0]              j_q;
   logic                    act_q;
   logic                    stb, packet, override, decay_en;

   // 9-bit signed mouse delta -> shifted, optionally negated, clamped step
   function automatic logic signed [31:0] scale_delta(input logic sgn, input logic [7:0] mag,
                                                      input logic neg);
      logic signed [31:0] v;
      v = {{24{sgn}}, mag};
      v = v >>> SHIFT;
      if (neg) v = -v;
      if (v > STEP_MAX) v = STEP_MAX;
      else if (v < -STEP_MAX) v = -STEP_MAX;
      return v;
   endfunction

   // accumulate and saturate to the WIDTH-bit signed range
   function automatic logic signed [WIDTH:0] sat_add(input logic signed [WIDTH:0] acc,
                                                     input logic signed [31:0] d);
      logic signed [31:0] s;
      s = 32'(acc) + d;
      if (s > AMAX) s = AMAX;
      else if (s < AMIN) s = AMIN;
      return s[WIDTH:0];
   endfunction

   // spring-return: one step toward zero
   function automatic logic signed [WIDTH:0] toward_zero(input logic signed [WIDTH:0] acc);
      if (acc == '0) return acc;
      return acc[WIDTH] ? acc + ONE : acc - ONE;
   endfunction

   // real stick byte sign-extended or truncated to the axis width
   function automatic logic signed [WIDTH-1:0] stick_ext(input logic [7:0] b);
      logic signed [31:0] t;
      t = {{24{b[7]}}, b};
      return t[WIDTH-1:0];
   endfunction

   assign stb      = bus.ps2_mouse[24];
   assign packet   = primed_q && (stb != old_stb_q);
   assign override = (bus.joya != 16'h0000) || bus.cpu_halt;

   logic unused_bits;
   assign unused_bits = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2]};

`ifdef MOUSE_AXIS_DECAY_EN
   localparam int CW = $clog2(DECAY_DIV + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;

   // free-running tick divider
   always_comb begin
      tick  = (cnt_q == CW'(DECAY_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // divider register
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign decay_en = bus.spring & tick;
`else
   logic unused_spring;
   assign unused_spring = bus.spring;
   assign decay_en      = 1'b0;
`endif

   // accumulator next state: override beats packet, packet beats decay tick
   always_comb begin
      emu_d     = emu_q;
      mx_d      = mx_q;
      my_d      = my_q;
      old_stb_d = stb;
      primed_d  = 1'b1;
      if (override) begin
         emu_d = 1'b0;
         mx_d  = '0;
         my_d  = '0;
      end else if (packet) begin
         emu_d = 1'b1;
         mx_d  = sat_add(mx_q, scale_delta(bus.ps2_mouse[4], bus.ps2_mouse[15:8], 1'b0));
         my_d  = sat_add(my_q, scale_delta(bus.ps2_mouse[5], bus.ps2_mouse[23:16],
                                           INVERT_Y != 0));
      end else if (decay_en && emu_q) begin
         mx_d = toward_zero(mx_q);
         my_d = toward_zero(my_q);
      end
   end

   // accumulator, strobe tracking and priming state
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         emu_q     <= 1'b0;
         mx_q      <= '0;
         my_q      <= '0;
         old_stb_q <= 1'b0;
         primed_q  <= 1'b0;
      end else begin
         emu_q     <= emu_d;
         mx_q      <= mx_d;
         my_q      <= my_d;
         old_stb_q <= old_stb_d;
         primed_q  <= primed_d;
      end
   end

   // registered output mux between mouse emulation and the real stick
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         ax_q  <= '0;
         ay_q  <= '0;
         j_q   <= '0;
         act_q <= 1'b0;
      end else begin
         act_q <= emu_q;
         if (emu_q) begin
            ax_q <= mx_q[WIDTH-1:0];
            ay_q <= my_q[WIDTH-1:0];
            j_q  <= {bus.joy[7], bus.ps2_mouse[1:0], bus.joy[4:0]};
         end else begin
            ax_q <= stick_ext(bus.joya[7:0]);
            ay_q <= stick_ext(bus.joya[15:8]);
            j_q  <= bus.joy;
         end
      end
   end

   assign bus.ax         = ax_q;
   assign bus.ay         = ay_q;
   assign bus.j          = j_q;
   assign bus.emu_active = act_q;
endmodule

// File: tb/tb_mouse_axis_emu.sv
// tb/tb_mouse_axis_emu.sv - self-checking bench for mouse_axis_emu against a behavioural model
module tb_mouse_axis_emu;
   localparam int W    = 8;
   localparam int SH   = 1;
   localparam int STEP = 10;
   localparam int INV  = 0;
   localparam int DIV  = 4;
`ifdef MOUSE_AXIS_DECAY_EN
   localparam bit SPRING_BUILT = 1'b1;
`else
   localparam bit SPRING_BUILT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mouse_axis_emu_if #(.WIDTH(W)) bus ();

   mouse_axis_emu #(
      .WIDTH(W), .SHIFT(SH), .STEP_MAX(STEP), .INVERT_Y(INV), .DECAY_DIV(DIV)
   ) dut (
      .clk_sys (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model state: positions as plain integers
   int   m_x, m_y, m_clk;
   bit   m_emu, m_primed, m_old;
   int   e_ax, e_ay;
   logic [7:0] e_j;
   bit   e_act;
   bit   stb;

   function automatic int floor_div(input int v, input int d);
      return (v >= 0) ? v / d : -((-v + d - 1) / d);
   endfunction

   function automatic int step_of(input bit s, input logic [7:0] b, input bit neg);
      int v;
      v = s ? int'(b) - 256 : int'(b);
      v = floor_div(v, 1 << SH);
      if (neg) v = -v;
      if (v > STEP) v = STEP;
      if (v < -STEP) v = -STEP;
      return v;
   endfunction

   function automatic int clip(input int v);
      int hi, lo;
      hi = (1 << (W - 1)) - 1;
      lo = -(1 << (W - 1));
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   function automatic int to_zero(input int v);
      return (v > 0) ? v - 1 : (v < 0) ? v + 1 : 0;
   endfunction

   task automatic model_reset();
      m_x = 0; m_y = 0; m_clk = 0;
      m_emu = 0; m_primed = 0; m_old = 0;
      e_ax = 0; e_ay = 0; e_j = 8'h00; e_act = 0;
   endtask

   // what one rising clock edge does, given the inputs currently driven
   task automatic model_step();
      bit pk, ovr, tk;
      if (!rst_n) return;
      e_act = m_emu;
      e_ax  = m_emu ? m_x : int'($signed(bus.joya[7:0]));
      e_ay  = m_emu ? m_y : int'($signed(bus.joya[15:8]));
      e_j   = m_emu ? {bus.joy[7], bus.ps2_mouse[1:0], bus.joy[4:0]} : bus.joy;
      pk  = m_primed && (bus.ps2_mouse[24] != m_old);
      m_old    = bus.ps2_mouse[24];
      m_primed = 1;
      ovr = (bus.joya != 0) || bus.cpu_halt;
      tk  = SPRING_BUILT && bus.spring && m_emu && ((m_clk % DIV) == DIV - 1);
      if (ovr) begin
         m_emu = 0; m_x = 0; m_y = 0;
      end else if (pk) begin
         m_emu = 1;
         m_x = clip(m_x + step_of(bus.ps2_mouse[4], bus.ps2_mouse[15:8], 1'b0));
         m_y = clip(m_y + step_of(bus.ps2_mouse[5], bus.ps2_mouse[23:16], INV != 0));
      end else if (tk) begin
         m_x = to_zero(m_x);
         m_y = to_zero(m_y);
      end
      m_clk++;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ax"},  bus.ax, 8'(e_ax));
      chk({tag, ".ay"},  bus.ay, 8'(e_ay));
      chk({tag, ".j"},   bus.j, e_j);
      chk({tag, ".act"}, {7'd0, bus.emu_active}, {7'd0, e_act});
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all("model");
   endtask

   task automatic drive_pkt(input int dx, input int dy, input logic [1:0] btn);
      logic [8:0] vx, vy;
      vx  = 9'(dx);
      vy  = 9'(dy);
      stb = ~stb;
      bus.ps2_mouse = {stb, vy[7:0], vx[7:0], 2'b00, vy[8], vx[8], 2'b00, btn};
   endtask

   task automatic send(input int dx, input int dy, input logic [1:0] btn);
      drive_pkt(dx, dy, btn);
      cyc();
   endtask

   initial begin
      int v, r, guard;
      rst_n = 1'b0;
      stb   = 1'b1;
      bus.ps2_mouse = 25'h1000000;
      bus.joya      = 16'h0000;
      bus.joy       = 8'hA5;
      bus.cpu_halt  = 1'b0;
      bus.spring    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");

      // release with strobe already high: priming must not count as a packet
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("idle_act", {7'd0, bus.emu_active}, 8'h00);
      chk("idle_ax", bus.ax, 8'h00);
      chk("idle_j", bus.j, 8'hA5);

      // dX=+40 -> 20 -> clamped 10; dY=-6 -> -3; buttons land on j[6:5]
      send(40, -6, 2'b10);
      cyc();
      chk("pkt_ax", bus.ax, 8'h0A);
      chk("pkt_ay", bus.ay, 8'hFD);
      chk("pkt_act", {7'd0, bus.emu_active}, 8'h01);
      chk("pkt_j", bus.j, 8'hC5);

      // back-to-back packets saturate at +127, then step back down
      repeat (14) send(40, 0, 2'b00);
      cyc();
      chk("sat_ax", bus.ax, 8'h7F);
      send(-40, 0, 2'b00);
      cyc();
      chk("unsat_ax", bus.ax, 8'h75);

      // real stick moves in the same clock as a packet: override wins
      bus.joya = 16'h0005;
      send(40, 0, 2'b11);
      cyc();
      chk("ovr_ax", bus.ax, 8'h05);
      chk("ovr_ay", bus.ay, 8'h00);
      chk("ovr_act", {7'd0, bus.emu_active}, 8'h00);
      chk("ovr_j", bus.j, 8'hA5);
      bus.joya = 16'h0000;
      cyc();

      // single-clock halt clears a position of 50; next packet restarts from 0
      repeat (5) send(40, 0, 2'b00);
      cyc();
      chk("pre_halt_ax", bus.ax, 8'h32);
      bus.cpu_halt = 1'b1;
      cyc();
      bus.cpu_halt = 1'b0;
      cyc();
      chk("halt_ax", bus.ax, 8'h00);
      chk("halt_act", {7'd0, bus.emu_active}, 8'h00);
      send(4, 0, 2'b00);
      cyc();
      chk("post_halt_ax", bus.ax, 8'h02);

      // random packets, stick movement and halts
      repeat (80) begin
         r = int'($urandom_range(0, 9));
         bus.joya     = (r == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
         bus.cpu_halt = (r == 1);
         bus.joy      = 8'($urandom);
         if (r < 7)
            send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                 2'($urandom));
         else
            cyc();
      end
      bus.joya     = 16'h0000;
      bus.cpu_halt = 1'b0;
      bus.joy      = 8'h3C;
      cyc();

      // reset arriving with a packet pending: packet lost, block re-primes
      drive_pkt(40, 40, 2'b01);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("reprime_act", {7'd0, bus.emu_active}, 8'h00);
      chk("reprime_ax", bus.ax, 8'h00);

`ifdef MOUSE_AXIS_DECAY_EN
      // spring return from +3 down to 0, then hold
      bus.spring = 1'b1;
      send(6, 0, 2'b00);
      repeat (18) cyc();
      chk("spring_zero_ax", bus.ax, 8'h00);
      chk("spring_act", {7'd0, bus.emu_active}, 8'h01);
      // packet on a tick clock: delta applied, decay step dropped
      send(6, 0, 2'b00);
      cyc();
      guard = 0;
      while ((m_clk % DIV) != DIV - 1 && guard < 8) begin
         cyc();
         guard++;
      end
      v = m_x;
      send(2, 0, 2'b00);
      cyc();
      chk("tick_pkt_ax", bus.ax, 8'(v + 1));
      repeat (40) begin
         if ($urandom_range(0, 1) == 1)
            send(int'($urandom_range(0, 24)) - 12, int'($urandom_range(0, 24)) - 12, 2'b00);
         else
            cyc();
      end
`else
      // spring input has no effect without the decay build: position holds
      bus.spring = 1'b1;
      send(6, 0, 2'b00);
      repeat (12) cyc();
      chk("hold_ax", bus.ax, 8'h03);
`endif
      bus.spring = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mouse_axis_emu.md
# mouse_axis_emu

Parametrised mouse-to-analog-axis emulator for the player-1 paddle/analog port. It accumulates PS/2 mouse packets from hps_io into signed X/Y axis positions and substitutes them, plus mouse buttons, for the real analog joystick while mouse emulation is active. It sits between hps_io and atari800top's JOY1X/JOY1Y/JOY1 inputs. Compared with the single-purpose inline logic, it adds configurable axis width, delta scaling and clamping, Y inversion, clean reset priming, and an optional spring-return mode.

## Interface
- WIDTH, 8: axis output width; accumulator range is -2^(WIDTH-1) .. 2^(WIDTH-1)-1.
- SHIFT, 1: arithmetic right shift applied to each 9-bit signed mouse delta.
- STEP_MAX, 10: per-packet delta clamp magnitude, applied after the shift.
- INVERT_Y, 0: when 1, the Y delta is negated before it is clamped.
- DECAY_DIV, 16384: period of the spring-return tick, in clocks.

- clk_sys  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ps2_mouse  in  25  hps_io mouse word: [24] toggle strobe, [1:0] buttons, [4]/[5] X/Y sign, [15:8] dX, [23:16] dY.
- joya  in  16  real analog stick: [7:0] X, [15:8] Y.
- joy  in  8  real digital joystick bits.
- cpu_halt  in  1  core halted (OSD/menu).
- spring  in  1  spring-return mode select; effective only when the decay macro is defined.
- ax, ay  out  WIDTH  axis outputs, signed.
- j  out  8  digital joystick bits out.
- emu_active  out  1  mouse emulation is engaged.

## Operation
- State:
  - emu flag.
  - Signed accumulators mx, my, each WIDTH+1 bits internally.
  - old_stb register and primed flag.
  - Decay counter.
- Priming: in the first clock after reset, old_stb loads ps2_mouse[24] and primed is set. No packet is processed in that clock.
- Packet: when primed and ps2_mouse[24] != old_stb:
  - dX = {sign4, dX byte} as 9-bit signed; dY = {sign5, dY byte}.
  - Shift each delta arithmetically right by SHIFT.
  - Negate dY if INVERT_Y.
  - Clamp each delta to ±STEP_MAX.
  - Add each delta to its accumulator, then saturate to the WIDTH range.
  - Set emu to 1.
- Override: when joya != 0 or cpu_halt is high, emu, mx and my are all cleared to 0. Override has priority over a packet in the same clock. old_stb still tracks the strobe.
- Output muxing:
  - emu=1: ax=mx[WIDTH-1:0], ay=my[WIDTH-1:0], j={joy[7], ps2_mouse[1:0], joy[4:0]}.
  - emu=0: ax=joya[7:0] sign-extended or truncated to WIDTH, ay likewise from joya[15:8], j=joy.
- Spring mode (only with the macro, spring=1, emu=1):
  - The counter wraps every DECAY_DIV clocks and generates a tick.
  - On a tick, each nonzero accumulator moves 1 toward zero.
  - If a packet arrives on the tick clock, the packet is applied and the tick is dropped. The counter keeps running.

## Timing
- All outputs are registered.
- Reset values: ax=0, ay=0, j=0, emu_active=0. Internally mx=my=0, primed=0, decay counter=0.
- Packet latency: a strobe toggle sampled at edge N appears on ax/ay/emu_active after edge N+1.
- Passthrough latency: joya/joy changes appear one clock later.
- Override latency: joya/cpu_halt asserted at edge N clears the outputs after edge N+1.
- Back-to-back toggles on consecutive clocks are each processed; there is no packet drop.
- If RESET_N is asserted mid-packet, state clears immediately and the packet is lost. The block re-primes after reset is released.

## Configuration
- MOUSE_AXIS_DECAY_EN:
  - Defined: the decay counter and spring-return logic are present, and `spring` selects the mode.
  - Undefined: the counter is not built, `spring` is ignored, and the block always accumulates (hold position).

## Test plan
- Reset release with ps2_mouse[24]=1, then idle -> no packet processed; emu_active=0; ax=ay=0.
- Toggle strobe with dX=+40, sign=0, dY=-6 (sign=1, byte 0xFA), defaults -> ax=+10 (20 clamped to 10), ay=-3, emu_active=1, j[6:5]=buttons.
- Fourteen packets of dX=+40 -> ax saturates at 127; one packet of dX=-40 then gives 117.
- With emu=1, set joya=0x0005 in the same clock as a strobe toggle -> emu_active=0, ax=5, ay=0, j=joy; the packet is ignored.
- Macro defined, spring=1, DECAY_DIV=4, mx=3 -> ax reads 2, 1, 0 at 4-clock intervals, then holds at 0. A packet coinciding with a tick applies the delta only.
- cpu_halt pulsed for 1 clock while emu=1, mx=50 -> ax=joya X, emu_active=0; the next packet of dX=+4 gives ax=2.
